// File: rtl/midi_pkg.sv
// Shared MIDI constants and the parser's FSM / running-status encodings.
// The oscillator also imports MIN_NOTE / MAX_NOTE from here.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] PROG_CHG = 4'hC;
  localparam logic [3:0] CH_PRESS = 4'hD;

  localparam logic [7:0] RT_MIN = 8'hF8;
  localparam logic [7:0] SC_MIN = 8'hF0;

  localparam logic [7:0] MIN_NOTE = 8'd0;
  localparam logic [7:0] MAX_NOTE = 8'd127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA1,
    ST_DATA2,
    ST_SKIP1,
    ST_SKIP2
  } state_t;

  typedef enum logic [2:0] {
    RUN_NONE,
    RUN_ON,
    RUN_OFF,
    RUN_SKIP1,
    RUN_SKIP2
  } run_t;

endpackage

// File: rtl/midi_note_parser_if.sv
// Byte-stream input and oscillator control outputs of the MIDI note parser.
// master = UART/bench side, slave = parser side.
interface midi_note_parser_if;

  logic       byteValid_i;
  logic [7:0] byte_i;
  logic [3:0] channel_i;
  logic [7:0] note_o;
  logic [6:0] velocity_o;
  logic       gate_o;
  logic       phaseRst_o;

  modport master (
    output byteValid_i, byte_i, channel_i,
    input  note_o, velocity_o, gate_o, phaseRst_o
  );

  modport slave (
    input  byteValid_i, byte_i, channel_i,
    output note_o, velocity_o, gate_o, phaseRst_o
  );

endinterface

// File: rtl/midi_note_parser.sv
// Monophonic last-note-priority Note On/Off decoder with running status.
// Define MIDI_CH_FILTER_EN to accept a single channel; otherwise omni.
module midi_note_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] DEFAULT_CH  = 4'd0,
  parameter bit         USE_CH_PORT = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  midi_note_parser_if.slave    bus
);

  state_t     state, state_nx;
  run_t       run, run_nx;
  logic [6:0] data1, data1_nx;
  logic       eval_on, eval_off;
  logic       ch_ok;
  logic [3:0] hi;

  logic [7:0] note_nx;
  logic [6:0] vel_nx;
  logic       gate_nx;
  logic       prst_nx;

  assign hi = bus.byte_i[7:4];

`ifdef MIDI_CH_FILTER_EN
  assign ch_ok = (bus.byte_i[3:0] == (USE_CH_PORT ? bus.channel_i : DEFAULT_CH));
`else
  logic unused_cfg;
  assign ch_ok      = 1'b1;
  assign unused_cfg = ^{bus.channel_i, DEFAULT_CH, USE_CH_PORT};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state          <= ST_IDLE;
      run            <= RUN_NONE;
      data1          <= '0;
      bus.note_o     <= MIN_NOTE;
      bus.velocity_o <= '0;
      bus.gate_o     <= 1'b0;
      bus.phaseRst_o <= 1'b0;
    end else begin
      state          <= state_nx;
      run            <= run_nx;
      data1          <= data1_nx;
      bus.note_o     <= note_nx;
      bus.velocity_o <= vel_nx;
      bus.gate_o     <= gate_nx;
      bus.phaseRst_o <= prst_nx;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    run_nx   = run;
    data1_nx = data1;
    eval_on  = 1'b0;
    eval_off = 1'b0;
    if (bus.byteValid_i) begin
      if (bus.byte_i >= RT_MIN) begin
        // realtime bytes are transparent, even mid-message
      end else if (bus.byte_i >= SC_MIN) begin
        run_nx   = RUN_NONE;
        state_nx = ST_IDLE;
      end else if (bus.byte_i[7]) begin
        case (hi)
          NOTE_OFF, NOTE_ON: begin
            if (ch_ok) begin
              run_nx   = (hi == NOTE_ON) ? RUN_ON : RUN_OFF;
              state_nx = ST_DATA1;
            end else begin
              run_nx   = RUN_SKIP2;
              state_nx = ST_SKIP1;
            end
          end
          PROG_CHG, CH_PRESS: begin
            run_nx   = RUN_SKIP1;
            state_nx = ST_SKIP2;
          end
          default: begin
            run_nx   = RUN_SKIP2;
            state_nx = ST_SKIP1;
          end
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            case (run)
              RUN_ON, RUN_OFF: begin
                data1_nx = bus.byte_i[6:0];
                state_nx = ST_DATA2;
              end
              RUN_SKIP2: state_nx = ST_SKIP2;
              default:   state_nx = ST_IDLE;
            endcase
          end
          ST_DATA1: begin
            data1_nx = bus.byte_i[6:0];
            state_nx = ST_DATA2;
          end
          ST_DATA2: begin
            state_nx = ST_IDLE;
            if (run == RUN_ON && bus.byte_i[6:0] != 7'd0) eval_on = 1'b1;
            else                                         eval_off = 1'b1;
          end
          ST_SKIP1: state_nx = ST_SKIP2;
          default:  state_nx = ST_IDLE;
        endcase
      end
    end
  end

  // Retriggering the held note still restarts the oscillator phase.
  always_comb begin
    note_nx = bus.note_o;
    vel_nx  = bus.velocity_o;
    gate_nx = bus.gate_o;
    prst_nx = 1'b0;
    if (eval_on) begin
      note_nx = {1'b0, data1} & MAX_NOTE;
      vel_nx  = bus.byte_i[6:0];
      gate_nx = 1'b1;
      prst_nx = 1'b1;
    end else if (eval_off && bus.gate_o && ({1'b0, data1} == bus.note_o)) begin
      gate_nx = 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench: stimulus pushes hand-computed output snapshots per cycle,
// a negedge monitor pops and compares them against the parser outputs.
module tb_midi_note_parser;

  typedef struct packed {
    logic [7:0] note;
    logic [6:0] vel;
    logic       gate;
    logic       prst;
  } snap_t;

  logic clk;
  logic nrst;

  midi_note_parser_if bus ();

  midi_note_parser #(.DEFAULT_CH(4'd0), .USE_CH_PORT(1'b1)) dut (
    .clk_i  (clk),
    .nrst_i (nrst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  snap_t      exp_q[$];
  string      name_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] e_note;
  logic [6:0] e_vel;
  logic       e_gate;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      snap_t e, g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = '{bus.note_o, bus.velocity_o, bus.gate_o, bus.phaseRst_o};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got note=%h vel=%h gate=%b prst=%b, want note=%h vel=%h gate=%b prst=%b",
                 nm, g.note, g.vel, g.gate, g.prst, e.note, e.vel, e.gate, e.prst);
      end
    end
  end

  task automatic push(input string nm, input logic p);
    exp_q.push_back('{e_note, e_vel, e_gate, p});
    name_q.push_back(nm);
  endtask

  // Byte that must not change the outputs.
  task automatic tx(input logic [7:0] b, input string nm);
    bus.byteValid_i = 1'b1;
    bus.byte_i      = b;
    @(posedge clk);
    push(nm, 1'b0);
    @(negedge clk);
    bus.byteValid_i = 1'b0;
  endtask

  // Final byte of a message with its expected result, then one idle cycle.
  task automatic txl(input logic [7:0] b, input string nm, input logic [7:0] n,
                     input logic [6:0] v, input logic g, input logic p);
    bus.byteValid_i = 1'b1;
    bus.byte_i      = b;
    @(posedge clk);
    e_note = n;
    e_vel  = v;
    e_gate = g;
    push(nm, p);
    @(negedge clk);
    bus.byteValid_i = 1'b0;
    @(posedge clk);
    push({nm, "_next"}, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst            = 1'b0;
    bus.byteValid_i = 1'b0;
    bus.byte_i      = 8'h00;
    bus.channel_i   = 4'd0;
    e_note = 8'h00; e_vel = 7'h00; e_gate = 1'b0;
    repeat (2) begin
      @(posedge clk);
      push("reset", 1'b0);
    end
    @(negedge clk);
    nrst = 1'b1;

    // 1: basic Note On
    tx(8'h90, "t1_status"); tx(8'h45, "t1_note");
    txl(8'h64, "t1_on", 8'h45, 7'h64, 1'b1, 1'b1);

    // 2: running status, off for another note, off for the held note
    tx(8'h48, "t2_note");
    txl(8'h40, "t2_run_on", 8'h48, 7'h40, 1'b1, 1'b1);
    tx(8'h45, "t2_off_other_n");
    txl(8'h00, "t2_off_other", 8'h48, 7'h40, 1'b1, 1'b0);
    tx(8'h48, "t2_off_cur_n");
    txl(8'h00, "t2_off_cur", 8'h48, 7'h40, 1'b0, 1'b0);

    // 3: realtime interleaving, same-note retrigger, explicit Note Off
    tx(8'h90, "t3_status"); tx(8'hF8, "t3_clock"); tx(8'h3C, "t3_note"); tx(8'hFE, "t3_sense");
    txl(8'h50, "t3_on", 8'h3C, 7'h50, 1'b1, 1'b1);
    tx(8'h3C, "t3_retrig_n");
    txl(8'h20, "t3_retrig", 8'h3C, 7'h20, 1'b1, 1'b1);
    tx(8'h80, "t3_off_s"); tx(8'h3C, "t3_off_n");
    txl(8'h40, "t3_off", 8'h3C, 7'h20, 1'b0, 1'b0);
    tx(8'h3C, "t3_off2_n");
    txl(8'h40, "t3_off_gated", 8'h3C, 7'h20, 1'b0, 1'b0);
    tx(8'h90, "t3_on2_s"); tx(8'h3C, "t3_on2_n");
    txl(8'h7F, "t3_on2", 8'h3C, 7'h7F, 1'b1, 1'b1);

    // 4: skipped messages and their running status
    tx(8'hC0, "t4_pc"); tx(8'h05, "t4_pc_d"); tx(8'h3C, "t4_skip1_a"); tx(8'h7F, "t4_skip1_b");
    tx(8'hB0, "t4_cc"); tx(8'h07, "t4_cc_d1"); tx(8'h64, "t4_cc_d2");
    tx(8'h08, "t4_cc_run1"); tx(8'h65, "t4_cc_run2");
    tx(8'h90, "t4_after_s"); tx(8'h3D, "t4_after_n");
    txl(8'h11, "t4_after", 8'h3D, 7'h11, 1'b1, 1'b1);

    // 5: channel filtering
    bus.channel_i = 4'd2;
`ifdef MIDI_CH_FILTER_EN
    tx(8'h91, "t5_ch1_s"); tx(8'h40, "t5_ch1_n"); tx(8'h40, "t5_ch1_rejected");
    tx(8'h92, "t5_ch2_s"); tx(8'h40, "t5_ch2_n");
    txl(8'h40, "t5_ch2_on", 8'h40, 7'h40, 1'b1, 1'b1);
`else
    tx(8'h91, "t5_ch1_s"); tx(8'h40, "t5_ch1_n");
    txl(8'h40, "t5_ch1_on", 8'h40, 7'h40, 1'b1, 1'b1);
    tx(8'h92, "t5_ch2_s"); tx(8'h41, "t5_ch2_n");
    txl(8'h40, "t5_ch2_on", 8'h41, 7'h40, 1'b1, 1'b1);
`endif
    bus.channel_i = 4'd0;

    // 6: syscommon abort, status abort in DATA2, reset mid-message
    tx(8'h90, "t6_s"); tx(8'h40, "t6_n"); tx(8'hF0, "t6_sysex"); tx(8'h50, "t6_orphan");
    tx(8'h90, "t6_ab_s"); tx(8'h30, "t6_ab_n"); tx(8'h90, "t6_ab_s2"); tx(8'h31, "t6_ab_n2");
    txl(8'h22, "t6_ab_on", 8'h31, 7'h22, 1'b1, 1'b1);
    tx(8'h90, "t6_rst_s"); tx(8'h40, "t6_rst_n");
    nrst = 1'b0;
    e_note = 8'h00; e_vel = 7'h00; e_gate = 1'b0;
    @(posedge clk);
    push("t6_reset_mid", 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    tx(8'h50, "t6_post_rst_data");
    tx(8'h90, "t6_rec_s"); tx(8'h3C, "t6_rec_n");
    txl(8'h10, "t6_recover", 8'h3C, 7'h10, 1'b1, 1'b1);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
